clusterv_periph_bridge: RTL and testbench
=========================================

Name: clusterv_periph_bridge

Overview:
- Registered Wishbone bridge between the 32-bit-address cluster system interconnect and the 16-bit-address register port of the peripheral subsystem.
- Sits directly upstream of the peripheral subsystem's register target port.
- Decodes a 64KB window, narrows the address, and allows one transaction in flight.
- Never hangs: a timeout watchdog returns err, and an error counter records failed accesses.

Parameters:
- BASE_ADR, 32'h4000_0000, window base; only bits [31:16] are compared.
- TIMEOUT, 64, cycles in REQ without a target ack/err before the bridge aborts (legal range 2..255).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- t_adr  in  32  upstream byte address.
- t_dat_w  in  32  upstream write data.
- t_dat_r  out  32  read data returned upstream.
- t_cyc  in  1  upstream cycle.
- t_stb  in  1  upstream strobe.
- t_we  in  1  upstream write enable.
- t_sel  in  4  upstream byte selects.
- t_ack  out  1  upstream ack.
- t_err  out  1  upstream error.
- i_adr  out  16  downstream address (t_adr[15:0]).
- i_dat_w  out  32  downstream write data.
- i_dat_r  in  32  downstream read data.
- i_cyc  out  1  downstream cycle.
- i_stb  out  1  downstream strobe.
- i_we  out  1  downstream write enable.
- i_sel  out  4  downstream byte selects.
- i_ack  in  1  downstream ack.
- i_err  in  1  downstream error.
- err_cnt  out  8  saturating count of error responses.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - t_ack=0, t_err=0, t_dat_r=0.
  - i_cyc=0, i_stb=0, i_we=0, i_sel=0, i_adr=0, i_dat_w=0.
  - timeout counter=0, err_cnt=0.
- All outputs are registered.
- IDLE:
  - When t_cyc&t_stb, capture adr/dat_w/we/sel.
  - hit = (t_adr[31:16]==BASE_ADR[31:16]).
  - hit: next state REQ; i_cyc=i_stb=1 from the next cycle.
  - miss: next state RESP with err=1; no downstream cycle is issued.
- REQ:
  - Hold i_cyc/i_stb and the captured fields stable.
  - Counter increments each REQ cycle.
  - i_ack=1: latch i_dat_r into t_dat_r (reads only; writes leave t_dat_r unchanged). Deassert i_cyc/i_stb on the next edge, go to RESP with ack.
  - i_err=1 (priority over i_ack if both are set): go to RESP with err.
  - Counter reaches TIMEOUT-1 with neither ack nor err: deassert i_cyc/i_stb, go to RESP with err. A late i_ack/i_err after the abort is ignored.
- RESP:
  - Exactly one cycle with t_ack=1 or t_err=1 (never both).
  - Counter clears; return to IDLE.
  - The next request is accepted in IDLE, earliest 1 cycle after the RESP pulse.
- Latency, hit with a zero-wait target acking in its first i_stb cycle:
  - t_stb at cycle 0, i_stb at cycle 1, t_ack at cycle 2.
  - Each target wait state adds 1 cycle.
- Miss latency: t_err at cycle 1.
- Upstream dropping t_cyc mid-transaction is ignored; the downstream access completes and a RESP pulse is still generated.
- err_cnt:
  - Increments on every RESP with err (decode miss, target err, or timeout).
  - Saturates at 255.
  - If err_clr and an increment coincide, the result is 1. err_clr alone gives 0.
- Reset asserted mid-REQ: i_cyc drops immediately (asynchronous); no response is issued after reset.

Test Plan:
1. Write 0x1234_5678 to 0x4000_0504, sel=4'hF, zero-wait target → i_adr=16'h0504, i_we=1, i_dat_w=0x12345678 at cycle 1; t_ack pulse at cycle 2; err_cnt=0.
2. Read 0x4000_0700, target acks after 3 wait states returning 0xCAFEF00D → t_dat_r=0xCAFEF00D with t_ack at cycle 5; i_stb held 4 cycles.
3. Read 0x5000_0000 → no i_cyc, t_err pulse at cycle 1, t_dat_r unchanged; err_cnt=1.
4. Target never responds, TIMEOUT=64 → i_cyc high for exactly 64 cycles, then t_err; i_ack asserted 2 cycles later is ignored (no extra t_ack); err_cnt increments.
5. Target asserts i_ack and i_err together → t_err only; 300 forced errors → err_cnt=255; err_clr coincident with an error → err_cnt=1.
6. Assert reset during REQ → i_cyc, t_ack, t_err, err_cnt=0 asynchronously; first access after reset release completes normally.

Source files
------------

// File: rtl/clusterv_periph_bridge.sv
// ---------------------------------------------------------------------------
// clusterv_periph_bridge
//
// Registered Wishbone bridge from the 32-bit-address cluster interconnect
// to the 16-bit-address register port of the peripheral subsystem. It
// decodes a 64KB window at BASE_ADR and narrows the address to 16 bits.
// Only one transaction is in flight at a time. A watchdog aborts target
// accesses that never complete, and a saturating counter records every
// error response.
//
// Ports
//   clock, reset          system clock, asynchronous active-low reset
//   t_adr/t_dat_w/t_cyc/  upstream request (32-bit byte address)
//   t_stb/t_we/t_sel
//   t_dat_r/t_ack/t_err   upstream response (single-cycle ack or err)
//   i_adr/i_dat_w/i_cyc/  downstream request (16-bit address)
//   i_stb/i_we/i_sel
//   i_dat_r/i_ack/i_err   downstream response
//   err_cnt               saturating count of error responses
//   err_clr               synchronous clear of err_cnt
// ---------------------------------------------------------------------------
module clusterv_periph_bridge #(
  parameter logic [31:0] BASE_ADR = 32'h4000_0000,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] t_adr,
  input  logic [31:0] t_dat_w,
  output logic [31:0] t_dat_r,
  input  logic        t_cyc,
  input  logic        t_stb,
  input  logic        t_we,
  input  logic [3:0]  t_sel,
  output logic        t_ack,
  output logic        t_err,
  output logic [15:0] i_adr,
  output logic [31:0] i_dat_w,
  input  logic [31:0] i_dat_r,
  output logic        i_cyc,
  output logic        i_stb,
  output logic        i_we,
  output logic [3:0]  i_sel,
  input  logic        i_ack,
  input  logic        i_err,
  output logic [7:0]  err_cnt,
  input  logic        err_clr
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] tmo_cnt;
  logic       req;
  logic       hit;
  logic       tmo_hit;
  logic       err_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign req     = t_cyc & t_stb;
  assign hit     = (t_adr[31:16] == BASE_ADR[31:16]);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Every path into RESP with err: decode miss, target err, or watchdog.
  assign err_inc = ((state == IDLE) && req && !hit) ||
                   ((state == REQ) && (i_err || (!i_ack && tmo_hit)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tmo_cnt <= 8'd0;
      t_dat_r <= 32'd0;
      t_ack   <= 1'b0;
      t_err   <= 1'b0;
      i_adr   <= 16'd0;
      i_dat_w <= 32'd0;
      i_cyc   <= 1'b0;
      i_stb   <= 1'b0;
      i_we    <= 1'b0;
      i_sel   <= 4'd0;
      err_cnt <= 8'd0;
    end else begin
      // A clear coinciding with a new error leaves exactly that one error.
      if (err_clr)      err_cnt <= {7'd0, err_inc};
      else if (err_inc) err_cnt <= sat_inc(err_cnt);

      case (state)
        IDLE: begin
          if (req) begin
            i_adr   <= t_adr[15:0];
            i_dat_w <= t_dat_w;
            i_we    <= t_we;
            i_sel   <= t_sel;
            if (hit) begin
              i_cyc <= 1'b1;
              i_stb <= 1'b1;
              state <= REQ;
            end else begin
              // Out-of-window: answer upstream directly, target never sees it.
              t_err <= 1'b1;
              state <= RESP;
            end
          end
        end

        REQ: begin
          if (i_err) begin
            i_cyc <= 1'b0;
            i_stb <= 1'b0;
            t_err <= 1'b1;
            state <= RESP;
          end else if (i_ack) begin
            if (!i_we) t_dat_r <= i_dat_r;
            i_cyc <= 1'b0;
            i_stb <= 1'b0;
            t_ack <= 1'b1;
            state <= RESP;
          end else if (tmo_hit) begin
            // Abort; any late target response lands in IDLE and is ignored.
            i_cyc <= 1'b0;
            i_stb <= 1'b0;
            t_err <= 1'b1;
            state <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        RESP: begin
          t_ack   <= 1'b0;
          t_err   <= 1'b0;
          tmo_cnt <= 8'd0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clusterv_periph_bridge.sv
// ---------------------------------------------------------------------------
// tb_clusterv_periph_bridge
//
// Directed bench for clusterv_periph_bridge. Inputs change 1ns after the
// rising edge and outputs are sampled at the same point. "Cycle N" means
// the cycle after the Nth rising edge following request issue.
// ---------------------------------------------------------------------------
module tb_clusterv_periph_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] t_adr, t_dat_w, t_dat_r;
  logic        t_cyc, t_stb, t_we;
  logic [3:0]  t_sel;
  logic        t_ack, t_err;
  logic [15:0] i_adr;
  logic [31:0] i_dat_w, i_dat_r;
  logic        i_cyc, i_stb, i_we;
  logic [3:0]  i_sel;
  logic        i_ack, i_err;
  logic [7:0]  err_cnt;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;
  int cnt;

  clusterv_periph_bridge #(.BASE_ADR(32'h4000_0000), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel),
    .t_ack(t_ack), .t_err(t_err),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_dat_r(i_dat_r),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel),
    .i_ack(i_ack), .i_err(i_err),
    .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one request in cycle 0, returns in cycle 1 with it withdrawn.
  task automatic issue(input logic [31:0] adr, input logic [31:0] dat,
                       input logic we, input logic [3:0] sel);
    t_adr = adr; t_dat_w = dat; t_we = we; t_sel = sel;
    t_cyc = 1'b1; t_stb = 1'b1;
    tick();
    t_cyc = 1'b0; t_stb = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    t_adr = '0; t_dat_w = '0; t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0; t_sel = '0;
    i_dat_r = '0; i_ack = 1'b0; i_err = 1'b0; err_clr = 1'b0;

    // Reset state
    #2;
    chk("rst_t_ack", {31'd0, t_ack}, 32'd0);
    chk("rst_t_err", {31'd0, t_err}, 32'd0);
    chk("rst_i_cyc", {31'd0, i_cyc}, 32'd0);
    chk("rst_t_dat_r", t_dat_r, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // 1: zero-wait write
    issue(32'h4000_0504, 32'h1234_5678, 1'b1, 4'hF);
    chk("t1_i_stb", {31'd0, i_stb}, 32'd1);
    chk("t1_i_adr", {16'd0, i_adr}, 32'h0504);
    chk("t1_i_we", {31'd0, i_we}, 32'd1);
    chk("t1_i_dat_w", i_dat_w, 32'h1234_5678);
    chk("t1_i_sel", {28'd0, i_sel}, 32'hF);
    chk("t1_ack_early", {31'd0, t_ack}, 32'd0);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    chk("t1_t_ack", {31'd0, t_ack}, 32'd1);
    chk("t1_t_err", {31'd0, t_err}, 32'd0);
    chk("t1_i_cyc_drop", {31'd0, i_cyc}, 32'd0);
    tick();
    chk("t1_ack_pulse", {31'd0, t_ack}, 32'd0);
    chk("t1_err_cnt", {24'd0, err_cnt}, 32'd0);

    // 2: read with three wait states
    issue(32'h4000_0700, 32'h0, 1'b0, 4'hF);
    chk("t2_i_stb_c1", {31'd0, i_stb}, 32'd1);
    chk("t2_i_adr", {16'd0, i_adr}, 32'h0700);
    tick(); tick(); tick();
    chk("t2_i_stb_c4", {31'd0, i_stb}, 32'd1);
    chk("t2_ack_c4", {31'd0, t_ack}, 32'd0);
    i_ack = 1'b1; i_dat_r = 32'hCAFE_F00D;
    tick();
    i_ack = 1'b0; i_dat_r = 32'h0;
    chk("t2_t_ack_c5", {31'd0, t_ack}, 32'd1);
    chk("t2_t_dat_r", t_dat_r, 32'hCAFE_F00D);
    chk("t2_i_stb_c5", {31'd0, i_stb}, 32'd0);
    tick();

    // 3: decode miss
    issue(32'h5000_0000, 32'h0, 1'b0, 4'hF);
    chk("t3_no_i_cyc", {31'd0, i_cyc}, 32'd0);
    chk("t3_t_err_c1", {31'd0, t_err}, 32'd1);
    chk("t3_t_ack", {31'd0, t_ack}, 32'd0);
    chk("t3_t_dat_r", t_dat_r, 32'hCAFE_F00D);
    chk("t3_err_cnt", {24'd0, err_cnt}, 32'd1);
    tick();
    chk("t3_err_pulse", {31'd0, t_err}, 32'd0);

    // 4: timeout, then late ack
    issue(32'h4000_0010, 32'h0, 1'b0, 4'hF);
    cnt = 0;
    for (int k = 0; k < 64; k++) begin
      if (i_cyc) cnt++;
      if (k < 63) tick();
    end
    tick();
    chk("t4_i_cyc_cycles", cnt, 32'd64);
    chk("t4_i_cyc_off", {31'd0, i_cyc}, 32'd0);
    chk("t4_t_err", {31'd0, t_err}, 32'd1);
    chk("t4_err_cnt", {24'd0, err_cnt}, 32'd2);
    tick(); tick();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    chk("t4_late_ack", {31'd0, t_ack}, 32'd0);
    tick();
    chk("t4_late_ack2", {30'd0, t_ack, t_err}, 32'd0);

    // 5: ack+err together, saturation, clear
    issue(32'h4000_0020, 32'h0, 1'b0, 4'hF);
    i_ack = 1'b1; i_err = 1'b1; i_dat_r = 32'hDEAD_DEAD;
    tick();
    i_ack = 1'b0; i_err = 1'b0; i_dat_r = 32'h0;
    chk("t5_both_t_err", {31'd0, t_err}, 32'd1);
    chk("t5_both_t_ack", {31'd0, t_ack}, 32'd0);
    chk("t5_both_dat_r", t_dat_r, 32'hCAFE_F00D);
    chk("t5_err_cnt3", {24'd0, err_cnt}, 32'd3);
    tick();
    for (int n = 0; n < 300; n++) begin
      issue(32'h5000_0000, 32'h0, 1'b0, 4'hF);
      tick();
    end
    chk("t5_saturate", {24'd0, err_cnt}, 32'd255);
    err_clr = 1'b1;
    issue(32'h6000_0000, 32'h0, 1'b0, 4'hF);
    err_clr = 1'b0;
    chk("t5_clr_inc", {24'd0, err_cnt}, 32'd1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_clr_only", {24'd0, err_cnt}, 32'd0);

    // 6: reset during REQ
    issue(32'h7000_0000, 32'h0, 1'b0, 4'hF);
    tick();
    chk("t6_pre_err_cnt", {24'd0, err_cnt}, 32'd1);
    issue(32'h4000_0030, 32'h0, 1'b0, 4'hF);
    tick();
    chk("t6_in_req", {31'd0, i_cyc}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_i_cyc", {31'd0, i_cyc}, 32'd0);
    chk("t6_async_resp", {30'd0, t_ack, t_err}, 32'd0);
    chk("t6_async_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("t6_async_dat_r", t_dat_r, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_no_resp", {30'd0, t_ack, t_err}, 32'd0);
    issue(32'h4000_0040, 32'h0, 1'b0, 4'h3);
    chk("t6_post_i_stb", {31'd0, i_stb}, 32'd1);
    chk("t6_post_i_sel", {28'd0, i_sel}, 32'h3);
    i_ack = 1'b1; i_dat_r = 32'h0BAD_BEEF;
    tick();
    i_ack = 1'b0; i_dat_r = 32'h0;
    chk("t6_post_ack", {31'd0, t_ack}, 32'd1);
    chk("t6_post_dat_r", t_dat_r, 32'h0BAD_BEEF);
    chk("t6_post_err_cnt", {24'd0, err_cnt}, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
